// File: rtl/led_pkg.sv
// Shared types and defaults for the LED mode sequencer: state encodings,
// default timing constants and the per-state output decode.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHL   = 2'b01,
    ST_SHR   = 2'b10,
    ST_FLASH = 2'b11
  } mode_t;

  localparam int DWELL_TICKS_DEF = 8;
  localparam int DB_CYCLES_DEF   = 1000000;

  // IDLE only ever leaves to SHL; the active modes rotate among themselves.
  function automatic mode_t next_mode(input mode_t m);
    mode_t n;
    case (m)
      ST_IDLE:  n = ST_SHL;
      ST_SHL:   n = ST_SHR;
      ST_SHR:   n = ST_FLASH;
      default:  n = ST_SHL;
    endcase
    return n;
  endfunction

  function automatic logic shift_of(input mode_t m);
    return (m == ST_SHR);
  endfunction

  function automatic logic func_of(input mode_t m);
    return (m == ST_FLASH);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each debounced press (0->1 of the debounced level).
module btn_debounce
  import led_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_ff;
  logic [CW-1:0] cnt;
  logic          level;

  // cnt counts consecutive synchronized samples that disagree with the
  // debounced level; the DB_CYCLES-th such sample commits the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= 2'b00;
      cnt     <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], btn};
      pulse   <= 1'b0;
      if (sync_ff[1] != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_ff[1];
          pulse <= sync_ff[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_mode_sequencer.sv
// LED display mode sequencer: IDLE -> SHL -> SHR -> FLASH -> SHL, advanced by
// a debounced step button or by dwell expiry. Optional pause: LED_SEQ_PAUSE_EN.
module led_mode_sequencer
  import led_pkg::*;
#(
  parameter int DWELL_TICKS = DWELL_TICKS_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       auto_en,
  input  logic       step_btn,
`ifdef LED_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic       shift_sel,
  output logic       func_sel,
  output logic       seq_clr,
  output logic [1:0] mode,
  output logic [7:0] dwell_left
);

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_TICKS - 1);

  // Reset asserts asynchronously but releases two edges later, so no state
  // change can happen before the second clock edge after release.
  logic [1:0] rst_ff;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_ff <= 2'b00;
    end else begin
      rst_ff <= {rst_ff[0], 1'b1};
    end
  end

  assign rst_n = rst_ff[1];

  logic step_pulse;

  btn_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (step_btn),
    .pulse(step_pulse)
  );

  logic paused;
`ifdef LED_SEQ_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  mode_t state;
  logic  auto_adv;
  logic  advance;

  // A step pulse and a dwell expiry in the same cycle collapse into one advance.
  always_comb begin
    auto_adv = tick & auto_en & ~paused;
    advance  = step_pulse |
               (auto_adv & ((state == ST_IDLE) | (dwell_left == 8'd0)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      shift_sel  <= 1'b0;
      func_sel   <= 1'b0;
      seq_clr    <= 1'b0;
      dwell_left <= 8'd0;
    end else if (advance) begin
      state      <= next_mode(state);
      shift_sel  <= shift_of(next_mode(state));
      func_sel   <= func_of(next_mode(state));
      seq_clr    <= 1'b1;
      dwell_left <= DWELL_LOAD;
    end else begin
      seq_clr <= 1'b0;
      if ((state != ST_IDLE) && auto_adv && (dwell_left != 8'd0)) begin
        dwell_left <= dwell_left - 8'd1;
      end
    end
  end

  assign mode = state;

endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 Parameter DWELL_TICKS, default 8: ticks spent in each active display mode under auto sequencing; legal range 1..255.
REQ-002 Parameter DB_CYCLES, default 1000000: clk cycles step_btn must be stable to count as a press (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-003 clk  input  1  master clock, 100 MHz.
REQ-004 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 tick  input  1  single-clk-cycle enable at the display rate (2 Hz), synchronous to clk.
REQ-006 auto_en  input  1  1 = advance modes on dwell expiry; 0 = advance on step presses only.
REQ-007 step_btn  input  1  raw, asynchronous push-button; 1 = pressed.
REQ-008 pause  input  1  freezes the dwell counter; present only when LED_SEQ_PAUSE_EN is defined.
REQ-009 shift_sel  output  1  shift direction to the shifter: 0 = left, 1 = right.
REQ-010 func_sel  output  1  display mux select: 0 = shift output, 1 = flash output.
REQ-011 seq_clr  output  1  one-cycle clear pulse to the shifter/flasher on every mode change.
REQ-012 mode  output  2  current state code.
REQ-013 dwell_left  output  8  ticks remaining in the current mode.

Function
REQ-014 The FSM SHALL have four states, encoded IDLE=00, SHL=01, SHR=10, FLASH=11.
REQ-015 Outputs per state SHALL be: IDLE and SHL give shift_sel=0, func_sel=0; SHR gives shift_sel=1, func_sel=0; FLASH gives shift_sel=0, func_sel=1.
REQ-016 step_btn SHALL pass through a 2-FF synchronizer, then a stability counter that updates the debounced level only after DB_CYCLES consecutive equal samples.
REQ-017 A 0->1 edge on the debounced level SHALL generate step_pulse for exactly one clk cycle.
REQ-018 IDLE SHALL go to SHL on step_pulse, or on tick when auto_en=1.
REQ-019 Active states SHALL advance SHL->SHR->FLASH->SHL.
REQ-020 An active state SHALL advance on step_pulse, or on tick when auto_en=1 and dwell_left=0.
REQ-021 On entry to any active state, dwell_left SHALL load DWELL_TICKS-1.
REQ-022 dwell_left SHALL decrement by 1 on each tick while auto_en=1 and no advance occurs that cycle.
REQ-023 dwell_left SHALL hold its value when auto_en=0.
REQ-024 dwell_left SHALL never decrement below 0.
REQ-025 step_pulse and dwell expiry in the same cycle SHALL produce exactly one advance.
REQ-026 All outputs SHALL be registered; the state change, new shift_sel/func_sel/mode and seq_clr=1 SHALL all appear in the clk cycle after the triggering cycle.
REQ-027 seq_clr SHALL be 0 in every cycle without a state change.
REQ-028 Changing auto_en mid-dwell SHALL neither reload dwell_left nor change state.

Reset
REQ-029 While reset=0, the block SHALL immediately force state IDLE, shift_sel=0, func_sel=0, seq_clr=0, mode=00, dwell_left=0, synchronizer FFs=0, debounce counter=0 and debounced level=0.
REQ-030 Reset deassertion SHALL be synchronized internally; the first state change SHALL occur no earlier than the second clk edge after release.
REQ-031 Reset asserted mid-mode SHALL abandon the mode without issuing seq_clr.

Configuration
REQ-032 With LED_SEQ_PAUSE_EN defined, the pause port SHALL exist, and pause=1 SHALL hold dwell_left and block auto advances; step_pulse advances SHALL still occur.
REQ-033 Without LED_SEQ_PAUSE_EN, the pause port and its logic SHALL be absent, with behaviour identical to pause=0.

Structure
REQ-034 A shared package led_pkg SHALL hold the 2-bit mode typedef, the four state encodings and the DWELL_TICKS/DB_CYCLES default constants.
REQ-035 Synchronizer, debounce and edge detection SHALL live in one sub-module, btn_debounce, instantiated once.

Verification
REQ-036 Reset released, auto_en=1, DWELL_TICKS=4, tick every 10 clk: IDLE->SHL on the first tick, then SHR, FLASH and SHL on every 4th tick thereafter; seq_clr pulses once per change.
REQ-037 auto_en=0, DB_CYCLES=16, step_btn held 20 cycles: exactly one advance, entering SHL from IDLE; 10-cycle glitches give no advance.
REQ-038 step_pulse coincident with a tick at dwell_left=0: a single advance (SHL->SHR, not FLASH); dwell_left=3 afterwards.
REQ-039 reset driven low while in FLASH with dwell_left=2: same-cycle mode=00, func_sel=0, dwell_left=0, no seq_clr.
REQ-040 LED_SEQ_PAUSE_EN defined, pause=1 for 6 ticks in SHR: dwell_left is constant and no advance occurs; a step press still advances to FLASH.
